fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined MIPS core. It owns the program counter, issues requests to a fixed-latency synchronous IMEM, and buffers returned instructions in a small queue. Decode consumes the queue through a valid/ready handshake, so the fetch stage supports real stalls. Branch/jump redirects and the external PC load flush all wrong-path work.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Constants shared by the pipelined MIPS core front end.
package pipe_pkg;

    localparam int unsigned PC_STEP_DEFAULT = 4;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, instr} entries between fetch and decode.
// The head is read from the register file, never bypassed from the push port.
module fetch_queue #(
    parameter int unsigned      WIDTH     = 40,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign head_valid = (count_q != '0);
    assign do_pop     = pop && head_valid;
    // A simultaneous pop frees the slot, so push-while-full is legal then.
    assign do_push    = push && (!full || do_pop);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (flush) begin
            // Head entry stays readable as a stale, don't-care value.
            wr_ptr_q <= rd_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            assert (!(push && full && !do_pop))
                else $error("fetch_queue: push while full");
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, fixed-latency IMEM request tracking with
// credit-based issue, and a decode-facing instruction queue.
module fetch_unit
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned IMEM_LAT = 1,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [PC_W-1:0]           load_val,
    input  logic                      redirect,
    input  logic [PC_W-1:0]           redirect_pc,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]        imem_rdata,
    output logic                      id_valid,
    output logic [INSTR_W-1:0]        id_instr,
    output logic [PC_W-1:0]           id_pc,
    input  logic                      id_ready,
    output logic [PC_W-1:0]           pc,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int unsigned CNT_W   = $clog2(QDEPTH) + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = PC_W + INSTR_W;
    localparam logic [PC_W-1:0]    PC_RESET    = PC_W'(RESET_PC);
    localparam logic [ENTRY_W-1:0] ENTRY_RESET = {PC_RESET, INSTR_W'(NOP_INSTR)};

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic               flush;
    logic               inflight_v_q  [IMEM_LAT];
    logic [PC_W-1:0]    inflight_pc_q [IMEM_LAT];
    logic [SUM_W-1:0]   inflight_cnt;
    logic [SUM_W-1:0]   occupancy;
    logic               credit;
    logic               q_push;
    logic [ENTRY_W-1:0] q_push_data;
    logic [ENTRY_W-1:0] q_head;

    assign flush = load || redirect;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < IMEM_LAT; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(inflight_v_q[i]);
        end
    end

    // Same-cycle pops are not credited back; keeps the check off the id_ready path.
    assign occupancy = SUM_W'(q_count) + inflight_cnt;
    assign credit    = (occupancy < SUM_W'(QDEPTH));
    assign imem_req  = reset && !flush && credit;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d = pc_q + PC_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Stage IMEM_LAT-1 lines up with the cycle its data is on imem_rdata.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int unsigned i = 0; i < IMEM_LAT; i++) begin
                inflight_v_q[i] <= 1'b0;
            end
        end else begin
            inflight_v_q[0]  <= imem_req;
            inflight_pc_q[0] <= pc_q;
            for (int unsigned i = 1; i < IMEM_LAT; i++) begin
                inflight_v_q[i]  <= inflight_v_q[i-1];
                inflight_pc_q[i] <= inflight_pc_q[i-1];
            end
        end
    end

    assign q_push      = inflight_v_q[IMEM_LAT-1];
    assign q_push_data = {inflight_pc_q[IMEM_LAT-1], imem_rdata};

    fetch_queue #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (QDEPTH),
        .RESET_VAL (ENTRY_RESET)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (q_push),
        .push_data  (q_push_data),
        .pop        (id_ready),
        .head_valid (id_valid),
        .head_data  (q_head),
        .count      (q_count)
    );

    assign {id_pc, id_instr} = q_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at IMEM_LAT=1, one at IMEM_LAT=3.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [7:0] a);
        return {8'hA5, a, ~a, 8'h3C};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Instance A: defaults (IMEM_LAT=1).
    logic        a_reset = 1'b0, a_load = 1'b0, a_redirect = 1'b0, a_ready = 1'b1;
    logic [7:0]  a_load_val = '0, a_redirect_pc = '0;
    logic        a_req, a_valid;
    logic [7:0]  a_addr, a_id_pc, a_pc;
    logic [31:0] a_rdata, a_id_instr;
    logic [2:0]  a_qc;
    logic [7:0]  a_addr_d1 = '0;

    always_ff @(posedge clk) a_addr_d1 <= a_addr;
    assign a_rdata = instr_of(a_addr_d1);

    fetch_unit u_dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .load        (a_load),
        .load_val    (a_load_val),
        .redirect    (a_redirect),
        .redirect_pc (a_redirect_pc),
        .imem_req    (a_req),
        .imem_addr   (a_addr),
        .imem_rdata  (a_rdata),
        .id_valid    (a_valid),
        .id_instr    (a_id_instr),
        .id_pc       (a_id_pc),
        .id_ready    (a_ready),
        .pc          (a_pc),
        .q_count     (a_qc)
    );

    // Instance B: IMEM_LAT=3.
    logic        b_reset = 1'b0, b_load = 1'b0, b_redirect = 1'b0, b_ready = 1'b1;
    logic [7:0]  b_load_val = '0, b_redirect_pc = '0;
    logic        b_req, b_valid;
    logic [7:0]  b_addr, b_id_pc, b_pc;
    logic [31:0] b_rdata, b_id_instr;
    logic [2:0]  b_qc;
    logic [7:0]  b_d1 = '0, b_d2 = '0, b_d3 = '0;

    always_ff @(posedge clk) begin
        b_d1 <= b_addr;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign b_rdata = instr_of(b_d3);

    fetch_unit #(.IMEM_LAT(3)) u_dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .load        (b_load),
        .load_val    (b_load_val),
        .redirect    (b_redirect),
        .redirect_pc (b_redirect_pc),
        .imem_req    (b_req),
        .imem_addr   (b_addr),
        .imem_rdata  (b_rdata),
        .id_valid    (b_valid),
        .id_instr    (b_id_instr),
        .id_pc       (b_id_pc),
        .id_ready    (b_ready),
        .pc          (b_pc),
        .q_count     (b_qc)
    );

    initial begin
        logic [7:0] wrap_seq [4];
        wrap_seq = '{8'hF8, 8'hFC, 8'h00, 8'h04};

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_qcount", 32'(a_qc), 0);
        check_eq("rst_valid", 32'(a_valid), 0);
        check_eq("rst_instr", a_id_instr, 0);
        check_eq("rst_idpc", 32'(a_id_pc), 0);
        check_eq("rst_pc", 32'(a_pc), 0);
        check_eq("rst_req", 32'(a_req), 0);

        // 1. Ramp
        next_cycle();
        a_reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("ramp_req", 32'(a_req), 1);
            check_eq("ramp_addr", 32'(a_addr), 32'(4 * k));
            check_eq("ramp_valid", 32'(a_valid), 32'(k >= 2));
            check_eq("ramp_qcount", 32'(a_qc), 32'(k >= 2));
            if (k >= 2) begin
                check_eq("ramp_idpc", 32'(a_id_pc), 32'(4 * (k - 2)));
                check_eq("ramp_instr", a_id_instr, instr_of(8'(4 * (k - 2))));
            end
            next_cycle();
        end

        // 2. Backpressure
        a_reset = 1'b0;
        a_ready = 1'b0;
        next_cycle();
        a_reset = 1'b1;
        repeat (8) next_cycle();
        a_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check_eq("bp_qcount", 32'(a_qc), 4);
                check_eq("bp_req", 32'(a_req), 0);
                check_eq("bp_pc", 32'(a_pc), 32'h10);
            end
            check_eq("bp_valid", 32'(a_valid), 1);
            check_eq("bp_idpc", 32'(a_id_pc), 32'(4 * j));
            next_cycle();
        end

        // 3. Redirect with 2 queued and 1 in flight
        a_reset = 1'b0;
        a_ready = 1'b0;
        next_cycle();
        a_reset = 1'b1;
        repeat (3) next_cycle();
        a_redirect    = 1'b1;
        a_redirect_pc = 8'h40;
        @(negedge clk);
        check_eq("redir_pre_qcount", 32'(a_qc), 2);
        check_eq("redir_pre_req", 32'(a_req), 0);
        next_cycle();
        a_redirect = 1'b0;
        a_ready    = 1'b1;
        @(negedge clk);
        check_eq("redir_valid", 32'(a_valid), 0);
        check_eq("redir_qcount", 32'(a_qc), 0);
        check_eq("redir_req", 32'(a_req), 1);
        check_eq("redir_addr", 32'(a_addr), 32'h40);
        next_cycle();
        @(negedge clk);
        check_eq("redir_stale_valid", 32'(a_valid), 0);
        next_cycle();
        @(negedge clk);
        check_eq("redir_first_valid", 32'(a_valid), 1);
        check_eq("redir_first_idpc", 32'(a_id_pc), 32'h40);
        check_eq("redir_first_instr", a_id_instr, instr_of(8'h40));
        next_cycle();
        @(negedge clk);
        check_eq("redir_second_idpc", 32'(a_id_pc), 32'h44);

        // 4. Load beats redirect
        next_cycle();
        a_load        = 1'b1;
        a_load_val    = 8'h20;
        a_redirect    = 1'b1;
        a_redirect_pc = 8'h40;
        next_cycle();
        a_load     = 1'b0;
        a_redirect = 1'b0;
        @(negedge clk);
        check_eq("ld_pc", 32'(a_pc), 32'h20);
        check_eq("ld_addr", 32'(a_addr), 32'h20);
        check_eq("ld_req", 32'(a_req), 1);
        check_eq("ld_valid", 32'(a_valid), 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("ld_first_valid", 32'(a_valid), 1);
        check_eq("ld_first_idpc", 32'(a_id_pc), 32'h20);

        // 5. PC wrap
        next_cycle();
        a_load     = 1'b1;
        a_load_val = 8'hF8;
        next_cycle();
        a_load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                check_eq("wrap_addr", 32'(a_addr), 32'(wrap_seq[k]));
            end
            if (k >= 2) begin
                check_eq("wrap_idpc", 32'(a_id_pc), 32'(wrap_seq[k-2]));
            end
            next_cycle();
        end

        // 6. Mid-run reset with IMEM_LAT=3
        b_reset    = 1'b1;
        b_load     = 1'b1;
        b_load_val = 8'h80;
        next_cycle();
        b_load = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("lat3_pre_req", 32'(b_req), 1);
        check_eq("lat3_pre_addr", 32'(b_addr), 32'h88);
        next_cycle();
        b_reset = 1'b0;
        #1;
        check_eq("lat3_rst_req", 32'(b_req), 0);
        next_cycle();
        b_reset = 1'b1;
        @(negedge clk);
        check_eq("lat3_rst_qcount", 32'(b_qc), 0);
        check_eq("lat3_rst_pc", 32'(b_pc), 0);
        check_eq("lat3_rst_idpc", 32'(b_id_pc), 0);
        check_eq("lat3_rst_instr", b_id_instr, 0);
        check_eq("lat3_post_addr", 32'(b_addr), 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 4) begin
                check_eq("lat3_no_stale", 32'(b_valid), 0);
            end else begin
                check_eq("lat3_first_valid", 32'(b_valid), 1);
                check_eq("lat3_first_idpc", 32'(b_id_pc), 0);
                check_eq("lat3_first_instr", b_id_instr, instr_of(8'h00));
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
